// File: rtl/stream_demux_pkg.sv
// Shared types for the stream demultiplexer.
//   demux_state_t : packet-position state (first beat vs. body of a packet)
//   port_sel_t    : output port index
package stream_demux_pkg;

  typedef enum logic {ST_SOP = 1'b0, ST_BODY = 1'b1} demux_state_t;

  typedef logic port_sel_t;

  localparam port_sel_t PORT0 = 1'b0;
  localparam port_sel_t PORT1 = 1'b1;

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry valid/ready register slice.
//   clk, rst            : clock, synchronous active-high reset
//   load                : capture in_data/in_last this cycle (caller guarantees room)
//   in_data, in_last    : beat to capture
//   out_ready           : downstream ready
//   out_data/valid/last : registered beat presented downstream
// A load in the same cycle as a drain replaces the old beat and keeps valid high.
module stream_reg_slice #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  output logic         out_last
);

  logic [N-1:0] data_r;
  logic         last_r;
  logic         valid_r;

  // Slice storage: load wins over drain, otherwise hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r  <= {N{1'b0}};
      last_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= in_data;
      last_r  <= in_last;
      valid_r <= 1'b1;
    end else if (valid_r && out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign out_last  = last_r;

endmodule

// File: rtl/stream_demux.sv
// Routes one valid/ready packet stream to one of two outputs.
//   s_data/s_valid/s_last/s_ready : input stream
//   select                        : port choice, sampled on the first beat of a packet
//   m0_* / m1_*                   : output streams, each behind a one-entry slice
//   busy                          : a packet is partly transferred
//   pkt_cnt0/pkt_cnt1             : wrapping counts of packets completed per port
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             select,
  output logic [N-1:0]     m0_data,
  output logic             m0_valid,
  output logic             m0_last,
  input  logic             m0_ready,
  output logic [N-1:0]     m1_data,
  output logic             m1_valid,
  output logic             m1_last,
  input  logic             m1_ready,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  demux_state_t     state_r;
  port_sel_t        route_r;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  port_sel_t tgt_s;
  logic      ready_s;
  logic      accept_s;
  logic      load0_s;
  logic      load1_s;

  // Target port: live select on a first beat, latched route inside a packet.
  always_comb begin
    tgt_s = PORT0;
    if (state_r == ST_SOP) begin
      tgt_s = select;
    end else begin
      tgt_s = route_r;
    end
  end

  // Input ready follows only the target slice; s_valid is deliberately not used.
  always_comb begin
    ready_s = 1'b0;
    case (tgt_s)
      PORT0:   ready_s = !m0_valid || m0_ready;
      PORT1:   ready_s = !m1_valid || m1_ready;
      default: ready_s = 1'b0;
    endcase
  end

  assign s_ready  = ready_s;
  assign accept_s = s_valid && ready_s;
  assign load0_s  = accept_s && (tgt_s == PORT0);
  assign load1_s  = accept_s && (tgt_s == PORT1);

  // Packet-position FSM and route latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_SOP;
      route_r <= PORT0;
    end else begin
      case (state_r)
        ST_SOP: begin
          if (accept_s && !s_last) begin
            state_r <= ST_BODY;
            route_r <= select;
          end else begin
            state_r <= ST_SOP;
          end
        end
        ST_BODY: begin
          if (accept_s && s_last) begin
            state_r <= ST_SOP;
          end else begin
            state_r <= ST_BODY;
          end
        end
        default: begin
          state_r <= ST_SOP;
          route_r <= PORT0;
        end
      endcase
    end
  end

  // Completed-packet counters; a last beat leaving a slice ends a packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_r <= {CNT_W{1'b0}};
      cnt1_r <= {CNT_W{1'b0}};
    end else begin
      if (m0_valid && m0_ready && m0_last) begin
        cnt0_r <= cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (m1_valid && m1_ready && m1_last) begin
        cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign busy     = (state_r == ST_BODY);
  assign pkt_cnt0 = cnt0_r;
  assign pkt_cnt1 = cnt1_r;

  stream_reg_slice #(.N(N)) u_slice0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load0_s),
    .in_data   (s_data),
    .in_last   (s_last),
    .out_ready (m0_ready),
    .out_data  (m0_data),
    .out_valid (m0_valid),
    .out_last  (m0_last)
  );

  stream_reg_slice #(.N(N)) u_slice1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1_s),
    .in_data   (s_data),
    .in_last   (s_last),
    .out_ready (m1_ready),
    .out_data  (m1_data),
    .out_valid (m1_valid),
    .out_last  (m1_last)
  );

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux with a per-port pending-beat model
// checked every cycle, plus literal spot checks.
module tb_stream_demux;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       select;
  logic [3:0] m0_data;
  logic       m0_valid;
  logic       m0_last;
  logic       m0_ready;
  logic [3:0] m1_data;
  logic       m1_valid;
  logic       m1_last;
  logic       m1_ready;
  logic       busy;
  logic [7:0] pkt_cnt0;
  logic [7:0] pkt_cnt1;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Model: one pending beat per port, packet position, latched route, counters.
  bit       md_inpkt;
  bit       md_route;
  bit       md_v[2];
  bit [3:0] md_d[2];
  bit       md_l[2];
  int       md_cnt[2];

  always #5 clk = ~clk;

  stream_demux #(.N(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .select(select),
    .m0_data(m0_data), .m0_valid(m0_valid), .m0_last(m0_last), .m0_ready(m0_ready),
    .m1_data(m1_data), .m1_valid(m1_valid), .m1_last(m1_last), .m1_ready(m1_ready),
    .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the inputs held during the cycle.
  always @(posedge clk) begin
    bit rdy[2];
    bit tgt;
    bit acc;
    rdy[0] = m0_ready;
    rdy[1] = m1_ready;
    if (rst) begin
      md_inpkt = 1'b0;
      md_route = 1'b0;
      for (int p = 0; p < 2; p++) begin
        md_v[p] = 1'b0; md_d[p] = 4'd0; md_l[p] = 1'b0; md_cnt[p] = 0;
      end
    end else begin
      tgt = md_inpkt ? md_route : select;
      acc = s_valid && (!md_v[tgt] || rdy[tgt]);
      for (int p = 0; p < 2; p++) begin
        if (md_v[p] && rdy[p]) begin
          if (md_l[p]) md_cnt[p] = (md_cnt[p] + 1) % 256;
          md_v[p] = 1'b0;
        end
      end
      if (acc) begin
        md_v[tgt] = 1'b1;
        md_d[tgt] = s_data;
        md_l[tgt] = s_last;
        if (!md_inpkt && !s_last) begin
          md_inpkt = 1'b1;
          md_route = select;
        end else if (md_inpkt && s_last) begin
          md_inpkt = 1'b0;
        end
      end
    end
  end

  // Compare process: mid-cycle, every cycle once out of the first reset.
  always @(negedge clk) begin
    bit tgt;
    bit exp_rdy;
    if (check_en) begin
      tgt = md_inpkt ? md_route : select;
      exp_rdy = tgt ? (!md_v[1] || m1_ready) : (!md_v[0] || m0_ready);
      chk("s_ready", s_ready, exp_rdy);
      chk("m0_valid", m0_valid, md_v[0]);
      chk("m1_valid", m1_valid, md_v[1]);
      if (md_v[0]) begin
        chk("m0_data", m0_data, md_d[0]);
        chk("m0_last", m0_last, md_l[0]);
      end
      if (md_v[1]) begin
        chk("m1_data", m1_data, md_d[1]);
        chk("m1_last", m1_last, md_l[1]);
      end
      chk("busy", busy, md_inpkt);
      chk("pkt_cnt0", pkt_cnt0, md_cnt[0]);
      chk("pkt_cnt1", pkt_cnt1, md_cnt[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until the DUT accepts it (bounded).
  task automatic send(input logic [3:0] d, input logic l, input logic sel);
    bit acc;
    bit done;
    s_data = d; s_last = l; select = sel; s_valid = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_data = 4'd0; s_valid = 1'b0; s_last = 1'b0; select = 1'b0;
    m0_ready = 1'b1; m1_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_en = 1'b1;
    chk("rst_m0_valid", m0_valid, 1'b0);
    chk("rst_m1_valid", m1_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt0", pkt_cnt0, 8'd0);
    tick();

    // 1: three-beat packet to port 1
    send(4'd1, 1'b0, 1'b1);
    chk("t1_m1_data1", m1_data, 4'd1);
    chk("t1_busy", busy, 1'b1);
    send(4'd2, 1'b0, 1'b1);
    send(4'd3, 1'b1, 1'b1);
    chk("t1_m1_data3", m1_data, 4'd3);
    chk("t1_m1_last", m1_last, 1'b1);
    chk("t1_m0_valid", m0_valid, 1'b0);
    tick(); tick();
    chk("t1_cnt1", pkt_cnt1, 8'd1);

    // 2: select toggles inside a port-1 packet
    send(4'd4, 1'b0, 1'b1);
    send(4'd5, 1'b0, 1'b0);
    chk("t2_busy", busy, 1'b1);
    chk("t2_m1_data5", m1_data, 4'd5);
    send(4'd6, 1'b1, 1'b0);
    chk("t2_m1_data6", m1_data, 4'd6);
    chk("t2_busy_end", busy, 1'b0);
    chk("t2_m0_valid", m0_valid, 1'b0);
    tick(); tick();

    // 3: port 0 stalls for four cycles mid-packet
    m0_ready = 1'b0;
    send(4'hA, 1'b0, 1'b0);
    s_data = 4'hB; s_last = 1'b0; s_valid = 1'b1;
    repeat (4) tick();
    chk("t3_m0_held", m0_data, 4'hA);
    chk("t3_s_ready", s_ready, 1'b0);
    m0_ready = 1'b1;
    send(4'hB, 1'b0, 1'b0);
    send(4'hC, 1'b1, 1'b0);
    tick(); tick();

    // 4: port 1 stalled, 1-beat packet to port 0 still flows
    m1_ready = 1'b0;
    send(4'd7, 1'b1, 1'b1);
    send(4'd8, 1'b1, 1'b0);
    chk("t4_m0_data", m0_data, 4'd8);
    chk("t4_m0_valid", m0_valid, 1'b1);
    chk("t4_m1_data", m1_data, 4'd7);
    chk("t4_m1_valid", m1_valid, 1'b1);
    m1_ready = 1'b1;
    tick(); tick();

    // 5: reset after beat 2 of a 4-beat packet
    send(4'd1, 1'b0, 1'b1);
    send(4'd2, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", busy, 1'b0);
    chk("t5_m0_valid", m0_valid, 1'b0);
    chk("t5_m1_valid", m1_valid, 1'b0);
    chk("t5_cnt1", pkt_cnt1, 8'd0);
    send(4'd9, 1'b0, 1'b0);
    chk("t5_m0_data", m0_data, 4'd9);
    chk("t5_m1_valid2", m1_valid, 1'b0);
    send(4'd3, 1'b1, 1'b1);
    chk("t5_m0_data2", m0_data, 4'd3);
    tick(); tick();
    chk("t5_cnt0", pkt_cnt0, 8'd1);

    // 6: 256 one-beat packets to port 0 wrap the counter back to 1
    for (int i = 0; i < 256; i++) begin
      send(i[3:0], 1'b1, 1'b0);
    end
    tick(); tick();
    chk("t6_cnt0_wrap", pkt_cnt0, 8'd1);
    chk("t6_cnt1", pkt_cnt1, 8'd0);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
